tf_seq: RTL and testbench
=========================

TF_SEQ -- requirements
Module: tf_seq

Interface
REQ-001 SHALL have parameter NUM_BASE, default 15, meaning the number of base words loaded per job.
REQ-002 SHALL have parameter NUM_CONST, default 14, meaning the number of constant words loaded per job.
REQ-003 SHALL have port clk, input, 1 bit, the single clock.
REQ-004 SHALL have port rst, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit, which begins a job; it is sampled in IDLE only.
REQ-006 SHALL have port num_stages, input, 4 bits, the stage count (1..15), captured at start.
REQ-007 SHALL have port stage_depth, input, `D_width bits, the number of reads per stage (>=1), captured at start.
REQ-008 SHALL have port in_valid, input, 1 bit, which qualifies in_data.
REQ-009 SHALL have port in_data, input, `D_width bits, the base words followed by the constant words.
REQ-010 SHALL have port in_ready, output, 1 bit, which is high only in LOAD_BASE and LOAD_CONST.
REQ-011 SHALL have port adv, input, 1 bit, the downstream butterfly stall release.
REQ-012 SHALL have port TF_base_bus, output, NUM_BASE*`D_width bits, where word i drives TF_base_in<i>.
REQ-013 SHALL have port TF_const_bus, output, NUM_CONST*`D_width bits, where word i drives TF_const_in<i>.
REQ-014 SHALL have ports TF_init_base and TF_init_const, outputs, 1 bit each, one-cycle load pulses.
REQ-015 SHALL have ports TF_ren and TF_wen, outputs, 1 bit each, the generator read and write-back strobes.
REQ-016 SHALL have port it_depth_cnt, output, `D_width bits, the in-stage read index.
REQ-017 SHALL have port l, output, `D_width bits, the current stage index.
REQ-018 SHALL have port LAST_STAGE, output, 1 bit, high while l == num_stages-1 in RUN.
REQ-019 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-020 SHALL have port done, output, 1 bit, a one-cycle pulse at job end.

Function
REQ-021 SHALL implement the states IDLE, LOAD_BASE, LOAD_CONST, INIT, RUN and DONE.
REQ-022 SHALL move IDLE->LOAD_BASE when start=1, capturing num_stages and stage_depth; start outside IDLE is ignored.
REQ-023 SHALL accept a word only when in_valid&&in_ready, writing it to the slot given by a word counter; the counter advances only on an accept.
REQ-024 SHALL move LOAD_BASE->LOAD_CONST on the NUM_BASE-th accept, and LOAD_CONST->INIT on the NUM_CONST-th accept, with no idle cycle between word streams.
REQ-025 SHALL, in INIT, assert TF_init_base and TF_init_const together for exactly one cycle, with the buses stable, then go to RUN with l=0 and it_depth_cnt=0.
REQ-026 SHALL, in RUN, set TF_ren=adv; it_depth_cnt increments on each TF_ren, and adv=0 holds all counters.
REQ-027 SHALL, on a TF_ren at it_depth_cnt==stage_depth-1, wrap it_depth_cnt to 0 and increment l; if l==num_stages-1, it instead goes to DONE.
REQ-028 SHALL make TF_wen a one-cycle-delayed copy of TF_ren, suppressed when LAST_STAGE was high for that read (the last stage issues no write-back).
REQ-029 SHALL, in DONE, pulse done for one cycle and return to IDLE; the buses retain their values until the next accept.
REQ-030 SHALL handle stage_depth==1 by incrementing l on every TF_ren.
REQ-031 SHALL handle num_stages==1 by holding LAST_STAGE high throughout RUN.
REQ-032 SHALL treat start with num_stages==0 or stage_depth==0 as a zero-length run: the load proceeds, INIT pulses, RUN is skipped, and done follows INIT.

Reset
REQ-033 SHALL, on rst=0 and at any state including mid-load or mid-RUN, immediately force IDLE and clear all outputs, buses, counters and captured configuration to 0.
REQ-034 SHALL emit no stale done or TF_wen pulse after rst is released.

Configuration
REQ-035 SHALL provide macro TF_SEQ_ABORT_EN; when it is defined, input abort (1 bit) exists.
REQ-036 SHALL, when TF_SEQ_ABORT_EN is defined, make abort=1 in any non-IDLE state go to IDLE next cycle, with no done pulse, TF_ren/TF_wen low from that cycle onward, and buses retained; abort has priority over all other transitions.
REQ-037 SHALL, when TF_SEQ_ABORT_EN is undefined, omit the abort port, so a job runs to DONE or reset.

Verification
REQ-038 SHALL cover a basic job: num_stages=3, stage_depth=4, 29 words 1..29 with in_valid always high -> in_ready high for 29 cycles, one init pulse, TF_base_bus word0=1, TF_const_bus word0=16, 12 TF_ren, 8 TF_wen, LAST_STAGE for the final 4 reads, done 1 cycle after the last read.
REQ-039 SHALL cover backpressure: in_valid toggling every cycle and adv toggling every cycle -> identical bus contents, identical read/write counts and no skipped it_depth_cnt values.
REQ-040 SHALL cover boundaries: stage_depth=1 with num_stages=1 -> exactly 1 TF_ren, 0 TF_wen, LAST_STAGE high, l=0; num_stages=0 -> done immediately after INIT.
REQ-041 SHALL cover reset mid-operation: rst=0 during RUN at l=1, it_depth_cnt=2 -> all outputs 0 asynchronously, then a new start completes normally.
REQ-042 SHALL cover abort (macro defined): abort at the 10th load word -> IDLE next cycle, busy=0, no done pulse, and a following job loads all 29 words afresh.

Source files
------------

// File: rtl/tf_seq_if.sv
// tf_seq_if: start/config, word-load handshake and generator-control bundle for tf_seq (abort under TF_SEQ_ABORT_EN)
`ifndef D_width
`define D_width 16
`endif
interface tf_seq_if #(
    parameter int NUM_BASE  = 15,
    parameter int NUM_CONST = 14
);
    logic                          start;
    logic [3:0]                    num_stages;
    logic [`D_width-1:0]           stage_depth;
    logic                          in_valid;
    logic [`D_width-1:0]           in_data;
    logic                          in_ready;
    logic                          adv;
    logic [NUM_BASE*`D_width-1:0]  TF_base_bus;
    logic [NUM_CONST*`D_width-1:0] TF_const_bus;
    logic                          TF_init_base;
    logic                          TF_init_const;
    logic                          TF_ren;
    logic                          TF_wen;
    logic [`D_width-1:0]           it_depth_cnt;
    logic [`D_width-1:0]           l;
    logic                          LAST_STAGE;
    logic                          busy;
    logic                          done;
`ifdef TF_SEQ_ABORT_EN
    logic                          abort;
`endif
    modport slave (
        input  start, num_stages, stage_depth, in_valid, in_data, adv,
`ifdef TF_SEQ_ABORT_EN
        input  abort,
`endif
        output in_ready, TF_base_bus, TF_const_bus, TF_init_base, TF_init_const,
               TF_ren, TF_wen, it_depth_cnt, l, LAST_STAGE, busy, done
    );
    modport master (
        output start, num_stages, stage_depth, in_valid, in_data, adv,
`ifdef TF_SEQ_ABORT_EN
        output abort,
`endif
        input  in_ready, TF_base_bus, TF_const_bus, TF_init_base, TF_init_const,
               TF_ren, TF_wen, it_depth_cnt, l, LAST_STAGE, busy, done
    );
endinterface

// File: rtl/tf_seq.sv
// tf_seq: twiddle-factor sequencer (load base/const words, init pulse, staged reads); TF_SEQ_ABORT_EN adds abort
`ifndef D_width
`define D_width 16
`endif
module tf_seq #(
    parameter int NUM_BASE  = 15,
    parameter int NUM_CONST = 14
) (
    input logic    clk,
    input logic    rst,
    tf_seq_if.slave tf
);
    localparam int W  = `D_width;
    localparam int CW = $clog2((NUM_BASE > NUM_CONST ? NUM_BASE : NUM_CONST) + 1);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] LOAD_BASE  = 3'd1;
    localparam logic [2:0] LOAD_CONST = 3'd2;
    localparam logic [2:0] INIT       = 3'd3;
    localparam logic [2:0] RUN        = 3'd4;
    localparam logic [2:0] DONE       = 3'd5;

    logic [2:0]             state_q, state_d;
    logic [3:0]             ns_q;
    logic [W-1:0]           sd_q;
    logic [W-1:0]           it_q, it_d;
    logic [W-1:0]           l_q, l_d;
    logic [CW-1:0]          wcnt_q, wcnt_d;
    logic [NUM_BASE*W-1:0]  base_q;
    logic [NUM_CONST*W-1:0] const_q;
    logic                   wen_q;
    logic                   abort_w, rdy, accept, wrap, last, ren, last_rd, zero;

`ifdef TF_SEQ_ABORT_EN
    assign abort_w = tf.abort && state_q != IDLE;
`else
    assign abort_w = 1'b0;
`endif

    // next-state, word counter and stage/read counters; abort overrides everything
    always_comb begin
        rdy     = state_q == LOAD_BASE || state_q == LOAD_CONST;
        accept  = tf.in_valid && rdy && !abort_w;
        wrap    = accept && (state_q == LOAD_BASE ? wcnt_q == CW'(NUM_BASE - 1)
                                                  : wcnt_q == CW'(NUM_CONST - 1));
        last    = state_q == RUN && l_q == W'(ns_q) - W'(1);
        ren     = state_q == RUN && tf.adv && !abort_w;
        last_rd = ren && it_q == sd_q - W'(1);
        zero    = ns_q == 4'd0 || sd_q == '0;
        state_d = abort_w                ? IDLE
                : state_q == IDLE        ? (tf.start ? LOAD_BASE : IDLE)
                : state_q == LOAD_BASE   ? (wrap ? LOAD_CONST : LOAD_BASE)
                : state_q == LOAD_CONST  ? (wrap ? INIT : LOAD_CONST)
                : state_q == INIT        ? (zero ? DONE : RUN)
                : state_q == RUN         ? (last_rd && last ? DONE : RUN)
                : IDLE;
        wcnt_d  = (!rdy || wrap) ? '0 : accept ? wcnt_q + CW'(1) : wcnt_q;
        it_d    = (state_q != RUN || last_rd) ? '0 : ren ? it_q + W'(1) : it_q;
        l_d     = state_q != RUN ? '0 : (last_rd && !last) ? l_q + W'(1) : l_q;
    end

    // control state, counters, configuration capture and delayed write-back strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ns_q    <= '0;
            sd_q    <= '0;
            wcnt_q  <= '0;
            it_q    <= '0;
            l_q     <= '0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            it_q    <= it_d;
            l_q     <= l_d;
            wen_q   <= ren && !last;
            if (state_q == IDLE && tf.start) begin
                ns_q <= tf.num_stages;
                sd_q <= tf.stage_depth;
            end
        end
    end

    // word store: accepted words land in the slot selected by the word counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q  <= '0;
            const_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_BASE; i++)
                if (state_q == LOAD_BASE && wcnt_q == CW'(i)) base_q[i*W +: W] <= tf.in_data;
            for (int i = 0; i < NUM_CONST; i++)
                if (state_q == LOAD_CONST && wcnt_q == CW'(i)) const_q[i*W +: W] <= tf.in_data;
        end
    end

    assign tf.in_ready      = rdy;
    assign tf.TF_base_bus   = base_q;
    assign tf.TF_const_bus  = const_q;
    assign tf.TF_init_base  = state_q == INIT;
    assign tf.TF_init_const = state_q == INIT;
    assign tf.TF_ren        = ren;
    assign tf.TF_wen        = wen_q && !abort_w;
    assign tf.it_depth_cnt  = it_q;
    assign tf.l             = l_q;
    assign tf.LAST_STAGE    = last;
    assign tf.busy          = state_q != IDLE;
    assign tf.done          = state_q == DONE && !abort_w;
endmodule

// File: tb/tb_tf_seq.sv
// tb_tf_seq: randomized directed bench for tf_seq, checked against a read-schedule model
`ifndef D_width
`define D_width 16
`endif
module tb_tf_seq;
    localparam int NB = 15;
    localparam int NC = 14;
    localparam int W  = `D_width;
    localparam int NW = NB + NC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    tf_seq_if #(.NUM_BASE(NB), .NUM_CONST(NC)) tf ();
    tf_seq #(.NUM_BASE(NB), .NUM_CONST(NC)) dut (.clk(clk), .rst(rst), .tf(tf));

    always #5 clk = ~clk;

    int m_ns, m_sd, rd_k, ren_cnt, wen_cnt, init_cnt, done_cnt, rdy_cnt, last_cnt;
    int cyc = 0, last_evt_cyc, done_cyc;
    logic prev_ren = 1'b0;
    logic [W-1:0]    words [NW];
    logic [NB*W-1:0] exp_base;
    logic [NC*W-1:0] exp_const;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // model: the k-th read of a job belongs to stage k/sd at index k%sd
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (tf.in_ready) rdy_cnt++;
            if (tf.TF_init_base) begin
                init_cnt++;
                last_evt_cyc = cyc;
                check("init_const", tf.TF_init_const, 1);
                check("init_base_bus", tf.TF_base_bus, exp_base);
                check("init_const_bus", tf.TF_const_bus, exp_const);
            end
            if (tf.TF_wen) begin
                wen_cnt++;
                check("wen_after_ren", prev_ren, 1);
            end
            if (tf.TF_ren) begin
                check("rd_it", tf.it_depth_cnt, rd_k % m_sd);
                check("rd_l", tf.l, rd_k / m_sd);
                check("rd_last", tf.LAST_STAGE, (rd_k / m_sd) == m_ns - 1);
                if (tf.LAST_STAGE) last_cnt++;
                rd_k++;
                ren_cnt++;
                last_evt_cyc = cyc;
            end
            if (tf.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_ren = tf.TF_ren;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int ns, input int sd, input bit seq);
        m_ns = ns; m_sd = sd; rd_k = 0; ren_cnt = 0; wen_cnt = 0; init_cnt = 0;
        done_cnt = 0; rdy_cnt = 0; last_cnt = 0; last_evt_cyc = -1; done_cyc = -100;
        for (int i = 0; i < NW; i++) words[i] = seq ? W'(i + 1) : W'($urandom);
        for (int i = 0; i < NB; i++) exp_base[i*W +: W] = words[i];
        for (int i = 0; i < NC; i++) exp_const[i*W +: W] = words[NB + i];
        tf.start = 1'b1;
        tf.num_stages = ns[3:0];
        tf.stage_depth = sd[W-1:0];
        tick();
        tf.start = 1'b0;
    endtask

    // vmode: 0 valid always, 1 toggling, 2 random; start/config wiggled to prove they are ignored
    task automatic load(input int vmode);
        int idx = 0;
        int budget = 400;
        bit v = 1'b1;
        while (idx < NW && budget > 0) begin
            tf.in_valid = vmode == 0 ? 1'b1 : vmode == 1 ? v : 1'($urandom_range(0, 1));
            v = ~v;
            tf.in_data = tf.in_valid ? words[idx] : W'($urandom);
            tf.start = 1'($urandom_range(0, 1));
            tf.num_stages = 4'($urandom);
            tf.stage_depth = W'($urandom);
            @(negedge clk);
            if (tf.in_valid && tf.in_ready) idx++;
            tick();
            budget--;
        end
        tf.in_valid = 1'b0;
        tf.start = 1'b0;
        check("load_timeout", budget > 0, 1);
    endtask

    // amode: 0 adv always, 1 toggling, 2 random; rst_l>=0 pulls reset at read (rst_l, rst_it)
    task automatic run(input int amode, input int rst_l, input int rst_it);
        int budget = 3000;
        bit a = 1'b1;
        while (done_cnt == 0 && budget > 0) begin
            tf.adv = amode == 0 ? 1'b1 : amode == 1 ? a : 1'($urandom_range(0, 1));
            a = ~a;
            @(negedge clk);
            if (rst_l >= 0 && tf.TF_ren && tf.l == W'(rst_l) && tf.it_depth_cnt == W'(rst_it)) begin
                #2 rst = 1'b0;
                #1;
                check("rst_async", {tf.busy, tf.TF_ren, tf.TF_wen, tf.done, tf.in_ready, tf.LAST_STAGE,
                                    tf.TF_init_base, tf.TF_init_const, tf.l, tf.it_depth_cnt,
                                    tf.TF_base_bus, tf.TF_const_bus}, 0);
                tf.adv = 1'b0;
                return;
            end
            tick();
            budget--;
        end
        tf.adv = 1'b0;
        check("run_timeout", budget > 0, 1);
    endtask

    task automatic finish_job(input int exp_rdy);
        int nr;
        tick();
        tick();
        nr = (m_ns == 0 || m_sd == 0) ? 0 : m_ns * m_sd;
        check("init_cnt", init_cnt, 1);
        check("ren_cnt", ren_cnt, nr);
        check("wen_cnt", wen_cnt, nr == 0 ? 0 : (m_ns - 1) * m_sd);
        check("last_cnt", last_cnt, nr == 0 ? 0 : m_sd);
        check("done_cnt", done_cnt, 1);
        check("done_lat", done_cyc - last_evt_cyc, 1);
        if (exp_rdy >= 0) check("rdy_cnt", rdy_cnt, exp_rdy);
        check("base_bus", tf.TF_base_bus, exp_base);
        check("const_bus", tf.TF_const_bus, exp_const);
        check("idle_busy", tf.busy, 0);
    endtask

    initial begin
        int vm;
        tf.start = 1'b0; tf.num_stages = '0; tf.stage_depth = '0;
        tf.in_valid = 1'b0; tf.in_data = '0; tf.adv = 1'b0;
`ifdef TF_SEQ_ABORT_EN
        tf.abort = 1'b0;
`endif
        #1 rst = 1'b0;
        #1;
        check("reset_state", {tf.busy, tf.done, tf.TF_ren, tf.TF_wen, tf.in_ready, tf.l,
                              tf.it_depth_cnt, tf.TF_base_bus, tf.TF_const_bus}, 0);
        tick();
        rst = 1'b1;
        tick();

        start_job(3, 4, 1'b1);
        load(0);
        run(0, -1, 0);
        finish_job(NW);
        check("base_w0", tf.TF_base_bus[W-1:0], 1);
        check("const_w0", tf.TF_const_bus[W-1:0], 16);

        start_job(3, 4, 1'b1);
        load(1);
        run(1, -1, 0);
        finish_job(-1);

        start_job(1, 1, 1'b0);
        load(2);
        run(2, -1, 0);
        finish_job(-1);

        start_job(0, 5, 1'b0);
        load(0);
        run(0, -1, 0);
        finish_job(NW);

        start_job(4, 0, 1'b0);
        load(0);
        run(1, -1, 0);
        finish_job(NW);

        for (int j = 0; j < 4; j++) begin
            vm = $urandom_range(0, 2);
            start_job($urandom_range(1, 15), $urandom_range(1, 6), 1'b0);
            load(vm);
            run($urandom_range(0, 2), -1, 0);
            finish_job(vm == 0 ? NW : -1);
        end

        start_job(3, 4, 1'b0);
        load(0);
        run(0, 1, 2);
        done_cnt = 0;
        wen_cnt = 0;
        ren_cnt = 0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_done", done_cnt, 0);
        check("post_rst_wen", wen_cnt + ren_cnt, 0);
        check("post_rst_busy", tf.busy, 0);
        start_job(2, 3, 1'b0);
        load(0);
        run(2, -1, 0);
        finish_job(NW);

`ifdef TF_SEQ_ABORT_EN
        start_job(3, 4, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tf.in_valid = 1'b1;
            tf.in_data = words[i];
            tf.abort = i == 9;
            tick();
        end
        tf.abort = 1'b0;
        tf.in_valid = 1'b0;
        check("abort_busy", tf.busy, 0);
        for (int i = 0; i < 4; i++) tick();
        check("abort_no_done", done_cnt + init_cnt + ren_cnt, 0);
        start_job(3, 4, 1'b0);
        load(0);
        run(0, -1, 0);
        finish_job(NW);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
